// File: rtl/bp_resolve_queue_pkg.sv
// Shared types and constants for the branch-resolution queue in front of the
// gshare update port.
package bp_resolve_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } bp_entry_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam int unsigned CNT_BITS_DEFAULT = 16;
    localparam int unsigned ENTRY_BITS       = $bits(bp_entry_t);

endpackage

// File: rtl/bp_resolve_queue_if.sv
// Execute-side and predictor-side signals of the resolve queue.
// The master drives the execute stage and pipeline hold; the slave is the queue.
interface bp_resolve_queue_if
    import bp_resolve_queue_pkg::*;
#(
    parameter int unsigned CNT_BITS = CNT_BITS_DEFAULT
) ();

    logic                ex_valid_i;
    logic                ex_is_branch_i;
    logic [31:0]         ex_pc_i;
    logic [31:0]         ex_target_i;
    logic                ex_taken_i;
    logic                ex_pred_taken_i;
    logic                update_hold_i;
    logic                stall_o;
    logic                flush_o;
    logic [31:0]         redirect_pc_o;
    logic                update_en_o;
    logic [31:0]         update_pc_o;
    logic                update_taken_o;
    logic [CNT_BITS-1:0] mispred_cnt_o;

    modport master (
        output ex_valid_i, ex_is_branch_i, ex_pc_i, ex_target_i, ex_taken_i,
               ex_pred_taken_i, update_hold_i,
        input  stall_o, flush_o, redirect_pc_o, update_en_o, update_pc_o,
               update_taken_o, mispred_cnt_o
    );

    modport slave (
        input  ex_valid_i, ex_is_branch_i, ex_pc_i, ex_target_i, ex_taken_i,
               ex_pred_taken_i, update_hold_i,
        output stall_o, flush_o, redirect_pc_o, update_en_o, update_pc_o,
               update_taken_o, mispred_cnt_o
    );

endinterface

// File: rtl/bp_sync_fifo.sv
// Synchronous FIFO with an occupancy count; reads zero when empty.
// Payload storage is not reset.
module bp_sync_fifo #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PTR_BITS = 2,
    parameter int unsigned WIDTH    = 33
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata,
    output logic [PTR_BITS:0]   count,
    output logic                full
);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_BITS:0]   count_q, count_d;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_BITS+1)'(1);
            2'b01:   count_d = count_q - (PTR_BITS+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == (PTR_BITS+1)'(DEPTH));
    assign rdata = (count_q == '0) ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/bp_resolve_queue.sv
// Captures resolved branches, flags mispredicts with a registered flush and
// redirect, and drains outcomes one per cycle into the predictor update port.
module bp_resolve_queue
    import bp_resolve_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PTR_BITS = 2,
    parameter int unsigned CNT_BITS = CNT_BITS_DEFAULT
) (
    input logic                 clk,
    input logic                 rst_n,
    bp_resolve_queue_if.slave   bus
);

    logic              push, pop, mispred, update_en, fifo_full;
    logic [PTR_BITS:0] fifo_count;
    bp_entry_t         wentry, head;

    logic                flush_q, flush_d;
    logic [31:0]         redirect_q, redirect_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    assign update_en = (fifo_count != '0);
    assign pop       = update_en & ~bus.update_hold_i;
    // A full queue still accepts a branch when the head leaves the same cycle.
    assign bus.stall_o = fifo_full & ~pop;
    assign push      = bus.ex_valid_i & bus.ex_is_branch_i & ~bus.stall_o;
    assign mispred   = push & (bus.ex_taken_i != bus.ex_pred_taken_i);
    assign wentry    = '{pc: bus.ex_pc_i, taken: bus.ex_taken_i};

    bp_sync_fifo #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS),
        .WIDTH    (ENTRY_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full)
    );

    always_comb begin
        flush_d    = mispred;
        redirect_d = redirect_q;
        cnt_d      = cnt_q;
        if (mispred) begin
            redirect_d = bus.ex_taken_i ? bus.ex_target_i : bus.ex_pc_i + PC_STEP;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
            cnt_q      <= '0;
        end else begin
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.flush_o        = flush_q;
    assign bus.redirect_pc_o  = redirect_q;
    assign bus.mispred_cnt_o  = cnt_q;
    assign bus.update_en_o    = update_en;
    assign bus.update_pc_o    = head.pc;
    assign bus.update_taken_o = head.taken;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue, built with a 4-bit mispredict counter
// so saturation is reachable quickly.
module tb_bp_resolve_queue;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bp_resolve_queue_if #(.CNT_BITS(4)) bus ();

    bp_resolve_queue #(
        .DEPTH    (4),
        .PTR_BITS (2),
        .CNT_BITS (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic taken, input logic pred);
        bus.ex_valid_i      = 1'b1;
        bus.ex_is_branch_i  = 1'b1;
        bus.ex_pc_i         = pc;
        bus.ex_target_i     = tgt;
        bus.ex_taken_i      = taken;
        bus.ex_pred_taken_i = pred;
    endtask

    task automatic idle();
        bus.ex_valid_i     = 1'b0;
        bus.ex_is_branch_i = 1'b0;
    endtask

    logic [31:0] pc;
    logic [31:0] exp_cnt;
    logic [31:0] drain_pc [3];
    logic        drain_tk [3];

    initial begin
        idle();
        bus.ex_pc_i         = '0;
        bus.ex_target_i     = '0;
        bus.ex_taken_i      = 1'b0;
        bus.ex_pred_taken_i = 1'b0;
        bus.update_hold_i   = 1'b0;

        // Reset
        #2 rst_n = 1'b0;
        #1;
        chk("rst_flush", {31'b0, bus.flush_o}, 32'd0);
        chk("rst_redirect", bus.redirect_pc_o, 32'd0);
        chk("rst_cnt", {28'b0, bus.mispred_cnt_o}, 32'd0);
        chk("rst_update_en", {31'b0, bus.update_en_o}, 32'd0);
        chk("rst_stall", {31'b0, bus.stall_o}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single correctly predicted branch
        present(32'h100, 32'h500, 1'b1, 1'b1);
        tick();
        idle();
        chk("corr_update_en", {31'b0, bus.update_en_o}, 32'd1);
        chk("corr_update_pc", bus.update_pc_o, 32'h100);
        chk("corr_update_taken", {31'b0, bus.update_taken_o}, 32'd1);
        chk("corr_flush", {31'b0, bus.flush_o}, 32'd0);
        chk("corr_cnt", {28'b0, bus.mispred_cnt_o}, 32'd0);
        tick();
        chk("corr_drained", {31'b0, bus.update_en_o}, 32'd0);
        chk("corr_empty_pc", bus.update_pc_o, 32'd0);
        chk("corr_flush_after", {31'b0, bus.flush_o}, 32'd0);

        // Mispredict, actually not taken
        present(32'h200, 32'h400, 1'b0, 1'b1);
        tick();
        idle();
        chk("mnt_flush", {31'b0, bus.flush_o}, 32'd1);
        chk("mnt_redirect", bus.redirect_pc_o, 32'h204);
        chk("mnt_cnt", {28'b0, bus.mispred_cnt_o}, 32'd1);
        chk("mnt_update_pc", bus.update_pc_o, 32'h200);
        chk("mnt_update_taken", {31'b0, bus.update_taken_o}, 32'd0);
        tick();
        chk("mnt_flush_drop", {31'b0, bus.flush_o}, 32'd0);
        chk("mnt_redirect_hold", bus.redirect_pc_o, 32'h204);

        // Mispredict, actually taken
        present(32'h300, 32'h80, 1'b1, 1'b0);
        tick();
        idle();
        chk("mt_flush", {31'b0, bus.flush_o}, 32'd1);
        chk("mt_redirect", bus.redirect_pc_o, 32'h80);
        chk("mt_cnt", {28'b0, bus.mispred_cnt_o}, 32'd2);
        tick();
        chk("mt_flush_drop", {31'b0, bus.flush_o}, 32'd0);

        // Fill under hold
        bus.update_hold_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            present(32'h1000 + 32'(4 * i), 32'h0, i[0], i[0]);
            tick();
        end
        present(32'h2000, 32'h3000, 1'b1, 1'b0);
        #1;
        chk("full_stall", {31'b0, bus.stall_o}, 32'd1);
        tick();
        chk("full_no_flush", {31'b0, bus.flush_o}, 32'd0);
        chk("full_no_cnt", {28'b0, bus.mispred_cnt_o}, 32'd2);
        chk("full_stall_kept", {31'b0, bus.stall_o}, 32'd1);
        chk("full_head_pc", bus.update_pc_o, 32'h1000);
        bus.update_hold_i = 1'b0;
        #1;
        chk("full_release_stall", {31'b0, bus.stall_o}, 32'd0);
        tick();
        idle();
        chk("pp_flush", {31'b0, bus.flush_o}, 32'd1);
        chk("pp_redirect", bus.redirect_pc_o, 32'h3000);
        chk("pp_cnt", {28'b0, bus.mispred_cnt_o}, 32'd3);
        chk("pp_head_pc", bus.update_pc_o, 32'h1004);
        chk("pp_head_taken", {31'b0, bus.update_taken_o}, 32'd1);
        drain_pc[0] = 32'h1008; drain_tk[0] = 1'b0;
        drain_pc[1] = 32'h100c; drain_tk[1] = 1'b1;
        drain_pc[2] = 32'h2000; drain_tk[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_en", {31'b0, bus.update_en_o}, 32'd1);
            chk("drain_pc", bus.update_pc_o, drain_pc[i]);
            chk("drain_taken", {31'b0, bus.update_taken_o}, {31'b0, drain_tk[i]});
        end
        tick();
        chk("drain_empty", {31'b0, bus.update_en_o}, 32'd0);

        // Back-to-back mispredicts into saturation, last one wraps the PC
        for (int i = 0; i < 13; i++) begin
            pc = (i == 12) ? 32'hFFFF_FFFC : 32'h4000 + 32'(16 * i);
            present(pc, 32'h9999, 1'b0, 1'b1);
            tick();
            exp_cnt = (i + 4 > 15) ? 32'd15 : 32'(i + 4);
            chk("b2b_flush", {31'b0, bus.flush_o}, 32'd1);
            chk("b2b_redirect", bus.redirect_pc_o, (i == 12) ? 32'h0 : pc + 32'd4);
            chk("b2b_cnt", {28'b0, bus.mispred_cnt_o}, exp_cnt);
        end
        idle();
        tick();
        chk("sat_flush_drop", {31'b0, bus.flush_o}, 32'd0);
        chk("sat_cnt", {28'b0, bus.mispred_cnt_o}, 32'd15);
        chk("sat_empty", {31'b0, bus.update_en_o}, 32'd0);

        // Non-branch and invalid branch are ignored
        present(32'h7000, 32'h7100, 1'b1, 1'b0);
        bus.ex_is_branch_i = 1'b0;
        tick();
        chk("nb_update_en", {31'b0, bus.update_en_o}, 32'd0);
        chk("nb_flush", {31'b0, bus.flush_o}, 32'd0);
        bus.ex_valid_i     = 1'b0;
        bus.ex_is_branch_i = 1'b1;
        tick();
        chk("nv_update_en", {31'b0, bus.update_en_o}, 32'd0);
        chk("nv_flush", {31'b0, bus.flush_o}, 32'd0);
        idle();

        // Reset in the middle of traffic
        bus.update_hold_i = 1'b1;
        present(32'h5000, 32'h6000, 1'b1, 1'b1);
        tick();
        present(32'h5004, 32'h7000, 1'b1, 1'b0);
        tick();
        idle();
        chk("mid_flush", {31'b0, bus.flush_o}, 32'd1);
        chk("mid_update_en", {31'b0, bus.update_en_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_flush", {31'b0, bus.flush_o}, 32'd0);
        chk("arst_redirect", bus.redirect_pc_o, 32'd0);
        chk("arst_cnt", {28'b0, bus.mispred_cnt_o}, 32'd0);
        chk("arst_update_en", {31'b0, bus.update_en_o}, 32'd0);
        chk("arst_update_pc", bus.update_pc_o, 32'd0);
        chk("arst_stall", {31'b0, bus.stall_o}, 32'd0);
        bus.update_hold_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_update_en", {31'b0, bus.update_en_o}, 32'd0);
        chk("post_rst_stall", {31'b0, bus.stall_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
